// File: rtl/col_pivot_if.sv
// Job/result handshake bundle for col_pivot_unit: the job side (in_*) and result side (out_*).
interface col_pivot_if #(
  parameter int NCOL    = 8,
  parameter int NROW    = 8,
  parameter int WL      = 16,
  parameter int NORM_WL = 24,
  parameter int OW      = $clog2(NCOL)
);
  logic                        in_valid;
  logic                        in_ready;
  logic [OW-1:0]               tarcol_i;
  logic [NROW*NCOL*WL-1:0]     Hmatrix_i;
  logic [NCOL*NORM_WL-1:0]     colnorm_i;
  logic [NCOL*OW-1:0]          colorder_i;
  logic                        out_valid;
  logic                        out_ready;
  logic [NROW*NCOL*WL-1:0]     Hmatrix_o;
  logic [NCOL*NORM_WL-1:0]     colnorm_o;
  logic [NCOL*OW-1:0]          colorder_o;
  logic [OW-1:0]               mincol_o;
  logic                        busy;

  modport master (
    output in_valid, tarcol_i, Hmatrix_i, colnorm_i, colorder_i, out_ready,
    input  in_ready, out_valid, Hmatrix_o, colnorm_o, colorder_o, mincol_o, busy
  );

  modport slave (
    input  in_valid, tarcol_i, Hmatrix_i, colnorm_i, colorder_i, out_ready,
    output in_ready, out_valid, Hmatrix_o, colnorm_o, colorder_o, mincol_o, busy
  );
endinterface

// File: rtl/col_pivot_unit.sv
// Sequential column-pivot stage: scans norms tarcol..NCOL-1 and swaps the minimum column into tarcol.
// Optional macro COLPIVOT_BACK2BACK_EN lets a new job be accepted in the same cycle a result retires.
module col_pivot_unit #(
  parameter int NCOL    = 8,
  parameter int NROW    = 8,
  parameter int WL      = 16,
  parameter int NORM_WL = 24,
  parameter int OW      = $clog2(NCOL)
) (
  input logic        clk,
  input logic        rst,
  col_pivot_if.slave bus
);
  localparam int HW = NROW * NCOL * WL;
  localparam int NW = NCOL * NORM_WL;
  localparam int RW = NCOL * OW;
  localparam logic [OW-1:0] LAST_COL = OW'(NCOL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] SWAP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_r;
  logic [HW-1:0]      h_r;
  logic [NW-1:0]      norm_r;
  logic [RW-1:0]      order_r;
  logic [OW-1:0]      tar_r;
  logic [OW-1:0]      min_idx_r;
  logic [OW-1:0]      scan_idx_r;
  logic [OW-1:0]      mincol_r;
  logic [NORM_WL-1:0] min_norm_r;
  logic               out_valid_r;

  logic [OW-1:0]      tar_in_s;
  logic [NORM_WL-1:0] tar_norm_s;
  logic [NORM_WL-1:0] scan_norm_s;
  logic               retire_s;
  logic               ready_s;
  logic               accept_s;
  logic [HW-1:0]      h_swp_s;
  logic [NW-1:0]      norm_swp_s;
  logic [RW-1:0]      order_swp_s;

  assign retire_s = (state_r == DONE) && out_valid_r && bus.out_ready;
  assign accept_s = bus.in_valid && ready_s;

  // Out-of-range targets (non-power-of-two NCOL) collapse onto the last column
  always_comb begin
    tar_in_s = bus.tarcol_i;
    if ({1'b0, bus.tarcol_i} > {1'b0, LAST_COL}) begin
      tar_in_s = LAST_COL;
    end else begin
      tar_in_s = bus.tarcol_i;
    end
    tar_norm_s  = bus.colnorm_i[int'(tar_in_s) * NORM_WL +: NORM_WL];
    scan_norm_s = norm_r[int'(scan_idx_r) * NORM_WL +: NORM_WL];
  end

  // Job acceptance: IDLE only, or also on a retiring result when back-to-back is enabled
  always_comb begin
    ready_s = 1'b0;
`ifdef COLPIVOT_BACK2BACK_EN
    if ((state_r == IDLE) || retire_s) begin
      ready_s = !rst;
    end else begin
      ready_s = 1'b0;
    end
`else
    if (state_r == IDLE) begin
      ready_s = !rst;
    end else begin
      ready_s = 1'b0;
    end
`endif
  end

  // Column exchange of tar_r and min_idx_r; identity when they coincide
  always_comb begin
    h_swp_s     = h_r;
    norm_swp_s  = norm_r;
    order_swp_s = order_r;
    for (int r = 0; r < NROW; r++) begin
      h_swp_s[(r * NCOL + int'(tar_r)) * WL +: WL]     = h_r[(r * NCOL + int'(min_idx_r)) * WL +: WL];
      h_swp_s[(r * NCOL + int'(min_idx_r)) * WL +: WL] = h_r[(r * NCOL + int'(tar_r)) * WL +: WL];
    end
    norm_swp_s[int'(tar_r) * NORM_WL +: NORM_WL]     = norm_r[int'(min_idx_r) * NORM_WL +: NORM_WL];
    norm_swp_s[int'(min_idx_r) * NORM_WL +: NORM_WL] = norm_r[int'(tar_r) * NORM_WL +: NORM_WL];
    order_swp_s[int'(tar_r) * OW +: OW]              = order_r[int'(min_idx_r) * OW +: OW];
    order_swp_s[int'(min_idx_r) * OW +: OW]          = order_r[int'(tar_r) * OW +: OW];
  end

  // Control FSM plus the working copy of the job, which doubles as the output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      h_r         <= '0;
      norm_r      <= '0;
      order_r     <= '0;
      tar_r       <= '0;
      min_idx_r   <= '0;
      scan_idx_r  <= '0;
      mincol_r    <= '0;
      min_norm_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
        end
        SCAN: begin
          // Strict compare: a tie keeps the earlier (lower) index
          if (scan_norm_s < min_norm_r) begin
            min_idx_r  <= scan_idx_r;
            min_norm_r <= scan_norm_s;
          end
          if (scan_idx_r == LAST_COL) begin
            state_r <= SWAP;
          end else begin
            scan_idx_r <= scan_idx_r + OW'(1);
          end
        end
        SWAP: begin
          h_r         <= h_swp_s;
          norm_r      <= norm_swp_s;
          order_r     <= order_swp_s;
          mincol_r    <= min_idx_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (retire_s) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (accept_s) begin
        h_r        <= bus.Hmatrix_i;
        norm_r     <= bus.colnorm_i;
        order_r    <= bus.colorder_i;
        tar_r      <= tar_in_s;
        min_idx_r  <= tar_in_s;
        min_norm_r <= tar_norm_s;
        scan_idx_r <= tar_in_s + OW'(1);
        state_r    <= (tar_in_s == LAST_COL) ? SWAP : SCAN;
      end
    end
  end

  assign bus.in_ready   = ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.Hmatrix_o  = h_r;
  assign bus.colnorm_o  = norm_r;
  assign bus.colorder_o = order_r;
  assign bus.mincol_o   = mincol_r;
  assign bus.busy       = (state_r != IDLE);
endmodule

// File: tb/tb_col_pivot_unit.sv
// Directed bench for col_pivot_unit (NCOL=8): pivot results, latency, stall, reset abort, back-to-back.
module tb_col_pivot_unit;
  localparam int NCOL = 8, NROW = 8, WL = 16, NORM_WL = 24, OW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  col_pivot_if #(.NCOL(NCOL), .NROW(NROW), .WL(WL), .NORM_WL(NORM_WL), .OW(OW)) bus ();

  col_pivot_unit #(.NCOL(NCOL), .NROW(NROW), .WL(WL), .NORM_WL(NORM_WL), .OW(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nrm[NCOL];
  int xord[NCOL];
  int seed;
  int lat;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WL-1:0] elem(input int s, input int r, input int c);
    return WL'(s * 4096 + r * 16 + c);
  endfunction

  task automatic load_inputs(input int tar, input int s);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        bus.Hmatrix_i[(r * NCOL + c) * WL +: WL] = elem(s, r, c);
    for (int c = 0; c < NCOL; c++) begin
      bus.colnorm_i[c * NORM_WL +: NORM_WL] = NORM_WL'(nrm[c]);
      bus.colorder_i[c * OW +: OW]          = OW'(c);
    end
    bus.tarcol_i = OW'(tar);
  endtask

  // Expected outputs are the inputs permuted by the hand-written order xord
  task automatic check_data(input int exp_min);
    logic [191:0] en, eo;
    logic [127:0] eh, gh;
    en = '0;
    eo = '0;
    check("mincol", 192'(bus.mincol_o), 192'(exp_min));
    for (int c = 0; c < NCOL; c++) begin
      en[c * NORM_WL +: NORM_WL] = NORM_WL'(nrm[xord[c]]);
      eo[c * OW +: OW]           = OW'(xord[c]);
    end
    check("colnorm", 192'(bus.colnorm_o), en);
    check("colorder", 192'(bus.colorder_o), eo);
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) eh[c * WL +: WL] = elem(seed, r, xord[c]);
      gh = bus.Hmatrix_o[r * NCOL * WL +: NCOL * WL];
      check("h_row", 192'(gh), 192'(eh));
    end
  endtask

  // lat counts cycles from the accept cycle to the first cycle with out_valid high
  task automatic run_job(input int tar);
    int   w;
    logic rdy_seen;
    @(negedge clk);
    load_inputs(tar, seed);
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept", 192'(bus.in_ready), 192'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      rdy_seen = rdy_seen | bus.in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_busy", 192'(rdy_seen), 192'(0));
    check("busy_done", 192'(bus.busy), 192'(1));
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("retire_valid", 192'(bus.out_valid), 192'(0));
    check("retire_idle", 192'(bus.busy), 192'(0));
  endtask

  initial begin
    int   t, t1;
    logic prev, found;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.tarcol_i   = '0;
    bus.Hmatrix_i  = '0;
    bus.colnorm_i  = '0;
    bus.colorder_i = '0;
    seed = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 192'(bus.out_valid), 192'(0));
    check("rst_in_ready", 192'(bus.in_ready), 192'(0));
    check("rst_busy", 192'(bus.busy), 192'(0));
    check("rst_mincol", 192'(bus.mincol_o), 192'(0));
    @(negedge clk);
    rst = 1'b0;

    // tarcol=0, tie between cols 1 and 3 resolved to 1
    seed = 1; nrm = '{5, 3, 9, 3, 7, 8, 6, 4}; xord = '{1, 0, 2, 3, 4, 5, 6, 7};
    run_job(0);
    check("lat_t0", 192'(lat), 192'(9));
    check_data(1);
    retire();

    // tarcol=2, entries below tarcol are smaller but must be ignored
    seed = 2; nrm = '{1, 1, 2, 6, 5, 9, 4, 3}; xord = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_job(2);
    check("lat_t2", 192'(lat), 192'(7));
    check_data(2);
    retire();

    // tarcol=7 goes straight to SWAP
    seed = 3; nrm = '{0, 0, 0, 0, 0, 0, 0, 9}; xord = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_job(7);
    check("lat_t7", 192'(lat), 192'(2));
    check_data(7);
    retire();

    // tarcol=3, min at col 6, result stalled for 5 cycles with a competing job offered
    seed = 4; nrm = '{1, 1, 1, 20, 15, 12, 4, 9}; xord = '{0, 1, 2, 6, 4, 5, 3, 7};
    bus.out_ready = 1'b0;
    run_job(3);
    check("lat_t3", 192'(lat), 192'(6));
    check_data(6);
    @(negedge clk);
    load_inputs(0, 5);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 192'(bus.out_valid), 192'(1));
      check("stall_ready", 192'(bus.in_ready), 192'(0));
      check_data(6);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    retire();

    // Reset in the middle of a tarcol=0 scan
    seed = 6; nrm = '{5, 3, 9, 3, 7, 8, 6, 4};
    @(negedge clk);
    load_inputs(0, seed);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scan_busy", 192'(bus.busy), 192'(1));
    rst = 1'b1;
    #1;
    check("abort_valid", 192'(bus.out_valid), 192'(0));
    check("abort_ready", 192'(bus.in_ready), 192'(0));
    check("abort_mincol", 192'(bus.mincol_o), 192'(0));
    check("abort_order", 192'(bus.colorder_o), 192'(0));
    check("abort_norm", 192'(bus.colnorm_o), 192'(0));
    check("abort_h", 192'(bus.Hmatrix_o[191:0]), 192'(0));
    @(negedge clk);
    rst = 1'b0;

    seed = 7; nrm = '{0, 9, 8, 7, 6, 5, 4, 10}; xord = '{0, 6, 2, 3, 4, 5, 1, 7};
    run_job(1);
    check("lat_t1", 192'(lat), 192'(8));
    check_data(6);
    retire();

    // Two tarcol=0 jobs with in_valid and out_ready held high
    seed = 8; nrm = '{5, 3, 9, 3, 7, 8, 6, 4}; xord = '{1, 0, 2, 3, 4, 5, 6, 7};
    @(negedge clk);
    load_inputs(0, seed);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_first", 192'(bus.out_valid), 192'(1));
    t1 = t;
    prev = bus.out_valid;
    found = 1'b0;
    while (!found && t < 80) begin
      @(posedge clk); #1;
      t++;
      if (bus.out_valid && !prev) found = 1'b1;
      prev = bus.out_valid;
    end
    bus.in_valid = 1'b0;
`ifdef COLPIVOT_BACK2BACK_EN
    check("b2b_gap", 192'(t - t1), 192'(9));
`else
    check("b2b_gap", 192'(t - t1), 192'(10));
`endif
    check_data(1);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/col_pivot_unit.md
Name: col_pivot_unit

Overview:
- Sequential, handshaked column-pivot stage for sorted-QR preprocessing in the MIMO detector.
- Accepts a channel matrix, per-column norms, the column order and a runtime target column.
- Scans the norms of columns tarcol..NCOL-1 one comparison per cycle, then swaps the minimum-norm column into tarcol.
- Generalises the fixed-TARCOL combinational exchange to parametric matrix size, a runtime target and valid/ready flow control.

Parameters:
- NCOL, 8, number of matrix columns (2..16)
- NROW, 8, number of matrix rows
- WL, 16, bit width of one matrix element
- NORM_WL, 24, bit width of one column norm (unsigned)
- OW, $clog2(NCOL), width of column index / order entries

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  job present
- in_ready  out  1  block can accept a job
- tarcol_i  in  OW  target column index
- Hmatrix_i  in  NROW*NCOL*WL  element (r,c) at bit (r*NCOL+c)*WL
- colnorm_i  in  NCOL*NORM_WL  norm c at bit c*NORM_WL; entries below tarcol ignored
- colorder_i  in  NCOL*OW  original index of column c at bit c*OW
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- Hmatrix_o  out  NROW*NCOL*WL  pivoted matrix, same packing
- colnorm_o  out  NCOL*NORM_WL  pivoted norms
- colorder_o  out  NCOL*OW  pivoted order
- mincol_o  out  OW  index selected as minimum
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; all data registers, mincol_o, out_valid = 0; in_ready=0 while rst is high.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready: register H, norms, order and tarcol. Set min_idx=tarcol, min_norm=norm[tarcol], scan_idx=tarcol+1. Go to SCAN, or to SWAP when tarcol==NCOL-1.
  - SCAN, one column per cycle: if norm[scan_idx] < min_norm (strict unsigned), update min_idx/min_norm. Ties keep the lower index. After comparing scan_idx==NCOL-1, go to SWAP; otherwise scan_idx++.
  - SWAP, one cycle: exchange column tarcol and column min_idx in the H, norm and order registers. If min_idx==tarcol, nothing changes. Columns below tarcol are always untouched. mincol_o <= min_idx. Go to DONE.
  - DONE: out_valid=1; all outputs held stable. On out_ready, go to IDLE (out_valid drops next cycle).
- Latency: out_valid rises NCOL-tarcol+1 cycles after the accept edge (NCOL=8: tarcol=0 -> 9 cycles; tarcol=7 -> 2 cycles). Throughput is one job per NCOL-tarcol+2 cycles without the optional feature.
- tarcol_i >= NCOL (non-power-of-two NCOL) is treated as NCOL-1.
- in_ready=0 in SCAN, SWAP and DONE; in_valid is ignored there.
- Outputs are registered only and never change while out_valid=1 and out_ready=0.
- Reset mid-job aborts the job; no partial result is emitted.

Optional Feature:
- Macro COLPIVOT_BACK2BACK_EN.
- Defined: in DONE, in_ready = out_ready. A same-cycle out_ready & in_valid retires the result and captures the new job, going straight to SCAN/SWAP. Throughput becomes NCOL-tarcol+1 cycles per job.
- Undefined: in_ready=1 only in IDLE, so jobs are separated by one idle cycle.

Test Plan (NCOL=8, order_i = 0..7):
- tarcol=0, norms [5,3,9,3,7,8,6,4] -> mincol_o=1 (tie with col3 resolved low); columns 0/1 and norms swapped; order_o=[1,0,2,3,4,5,6,7]; out_valid 9 cycles after accept.
- tarcol=2, norms [x,x,2,6,5,9,4,3] -> mincol_o=2; H, norms and order unchanged; out_valid after 7 cycles.
- tarcol=7 -> mincol_o=7, no change; out_valid 2 cycles after accept; in_ready=0 throughout.
- tarcol=3, min at col6; out_ready held low 5 cycles -> outputs and out_valid stable; in_ready=0; a concurrent in_valid is not captured; release -> IDLE next cycle.
- Assert rst during SCAN of a tarcol=0 job -> out_valid=0 and all outputs 0 immediately. After release, a new tarcol=1 job completes normally with correct latency (8 cycles).
- With COLPIVOT_BACK2BACK_EN: two tarcol=0 jobs, in_valid and out_ready held high -> second result 9 cycles after the first (10 without the macro).
